uart_rx_ctrl: RTL and testbench

UART receive controller that sequences the 16x oversampling tick into start-bit qualification, mid-bit data sampling and stop-bit checking. It sits between the baud/sample tick generator and the SoC receive datapath, and delivers one parallel byte per frame with a valid strobe or a framing-error strobe. All logic runs on the single system clock. The oversampling tick arrives as a one-cycle enable pulse, not as a derived clock.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 36 +++
 rtl/uart_rx_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions: receiver state encoding and the default frame
//   geometry used by the RX controller, the TX side and the tick generator.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

   // Default sample ticks per bit period and data bits per frame.
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
//   Two-flop synchronizer for an asynchronous, idle-high input. Both flops
//   reset to 1 so that a line in its idle state is not mistaken for activity
//   while the chain is coming out of reset.
//
//   Ports:
//     clk  input   system clock
//     rst  input   asynchronous, active-high reset
//     d    input   asynchronous input
//     q    output  input synchronized to clk (2 cycles of latency)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   // NOTE: non-blocking assignments make the second flop take the first
   // flop's pre-edge value, which is what builds the two-stage chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule : uart_sync2

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   UART receive controller. Uses a one-cycle oversampling enable to qualify
//   the start bit at its midpoint, sample each data bit at its midpoint and
//   check the stop bit, then presents the byte with a valid or framing-error
//   strobe.
//
//   Parameters:
//     OVERSAMPLE  sample ticks per bit period (even, >= 4)
//     DATA_BITS   data bits per frame (5..8), no parity, one stop bit
//
//   Ports:
//     clk          input   system clock
//     rst          input   asynchronous, active-high reset
//     sample_tick  input   one-cycle enable at OVERSAMPLE x baud rate
//     rx           input   asynchronous serial line, idle high
//     data_out     output  last received frame, LSB = first data bit
//     data_valid   output  one-cycle pulse: frame ended with stop bit = 1
//     frame_err    output  one-cycle pulse: stop bit sampled as 0
//     busy         output  high whenever a frame is in progress
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   // Tick count at the start-bit midpoint and at the end of a full bit period.
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic                 rx_s;

   uart_rx_state_e       state_q, state_d;
   logic [TW-1:0]        tick_q,  tick_d;
   logic [BW-1:0]        bit_q,   bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_d;
   logic                 valid_d;
   logic                 ferr_d;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // State, counters and outputs all register together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_out   <= data_d;
         data_valid <= valid_d;
         frame_err  <= ferr_d;
      end
   end

   always_comb begin
      // NOTE: every variable starts from its hold value (strobes from 0), so
      // no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_out;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      // Nothing moves between ticks; tick gaps of any length are harmless.
      if (sample_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s) begin
                  state_d = ST_START;
                  tick_d  = TW'(1);
               end
            end

            ST_START: begin
               if (tick_q == TICK_MID) begin
                  tick_d = '0;
                  if (!rx_s) begin
                     state_d = ST_DATA;
                     bit_d   = '0;
                  end else begin
                     // Line is high again at mid-start: a glitch, not a frame.
                     state_d = ST_IDLE;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end

            ST_DATA: begin
               // Counting restarts at mid-start, so a full period lands mid-bit.
               if (tick_q == TICK_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  tick_d  = '0;
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_STOP;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end

            ST_STOP: begin
               if (tick_q == TICK_LAST) begin
                  // The byte is delivered on framing errors too.
                  data_d  = shift_q;
                  valid_d = rx_s;
                  ferr_d  = !rx_s;
                  tick_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl: an 8-bit instance and a 5-bit instance
//   share clock, reset and a sample tick every 4 clk (16 ticks/bit, so one bit
//   lasts 64 clk). Inputs change 1 ns after the rising edge; outputs are
//   observed on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       rx  = 1'b1;
   logic       rx5 = 1'b1;

   logic [7:0] data_out;
   logic       data_valid, frame_err, busy;
   logic [4:0] data_out5;
   logic       data_valid5, frame_err5, busy5;

   int total = 0;
   int bad   = 0;

   uart_rx_ctrl u_dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(5)) u_dut5 (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx          (rx5),
      .data_out    (data_out5),
      .data_valid  (data_valid5),
      .frame_err   (frame_err5),
      .busy        (busy5)
   );

   always #5 clk = ~clk;

   // Sample tick: high for one clk out of every four.
   initial begin
      int div;
      div = 0;
      forever begin
         @(posedge clk);
         #1;
         sample_tick = (div == 0);
         div = (div + 1) % 4;
      end
   end

   // Strobe monitors, sampled on the falling edge.
   int         valid_cnt = 0, ferr_cnt = 0, both_cnt = 0, long_cnt = 0;
   int         busy_strobe_cnt = 0, busy_ticks = 0;
   logic [7:0] vlog [0:15];
   logic       valid_prev = 1'b0, ferr_prev = 1'b0;

   int         valid5_cnt = 0, ferr5_cnt = 0, busy5_ticks = 0;

   always @(negedge clk) begin
      if (data_valid) begin
         vlog[valid_cnt % 16] = data_out;
         valid_cnt++;
      end
      if (frame_err) ferr_cnt++;
      if (data_valid && frame_err) both_cnt++;
      if ((data_valid && valid_prev) || (frame_err && ferr_prev)) long_cnt++;
      if ((data_valid || frame_err) && busy) busy_strobe_cnt++;
      if (sample_tick && busy) busy_ticks++;
      valid_prev = data_valid;
      ferr_prev  = frame_err;

      if (data_valid5) valid5_cnt++;
      if (frame_err5) ferr5_cnt++;
      if (sample_tick && busy5) busy5_ticks++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx5 = v;
      else     rx  = v;
   endtask

   // Start bit, nbits data bits LSB first, then a stop bit of the given value
   // held for stop_clks before the line returns high.
   task automatic send_frame(input bit sel, input logic [7:0] d, input int nbits,
                             input logic stop, input int stop_clks);
      drive(sel, 1'b0);
      wait_clks(BIT_CLKS);
      for (int i = 0; i < nbits; i++) begin
         drive(sel, d[i]);
         wait_clks(BIT_CLKS);
      end
      drive(sel, stop);
      wait_clks(stop_clks);
      drive(sel, 1'b1);
   endtask

   int v0, f0, t0, v50, f50, t50;

   initial begin
      // ---------------- reset state ----------------
      wait_clks(10);
      @(negedge clk);
      check("rst_data",   32'(data_out),   32'h0);
      check("rst_valid",  32'(data_valid), 32'h0);
      check("rst_ferr",   32'(frame_err),  32'h0);
      check("rst_busy",   32'(busy),       32'h0);
      check("rst_data5",  32'(data_out5),  32'h0);
      check("rst_busy5",  32'(busy5),      32'h0);
      wait_clks(1);
      rst = 1'b0;
      wait_clks(20);

      // ---------------- good frame 0x55 ----------------
      v0 = valid_cnt; f0 = ferr_cnt; t0 = busy_ticks;
      send_frame(1'b0, 8'h55, 8, 1'b1, BIT_CLKS);
      wait_clks(2 * BIT_CLKS);
      @(negedge clk);
      check("f55_valid_n", 32'(valid_cnt - v0), 32'd1);
      check("f55_ferr_n",  32'(ferr_cnt - f0),  32'd0);
      check("f55_data",    32'(data_out),       32'h55);
      check("f55_busy",    32'(busy),           32'h0);
      // 152 ticks from detection to strobe; busy covers all but the first.
      check("f55_ticks",   32'(busy_ticks - t0), 32'd151);

      // ---------------- start glitch ----------------
      v0 = valid_cnt; f0 = ferr_cnt; t0 = busy_ticks;
      drive(1'b0, 1'b0);
      wait_clks(16);
      drive(1'b0, 1'b1);
      wait_clks(2 * BIT_CLKS);
      @(negedge clk);
      check("glitch_valid_n", 32'(valid_cnt - v0),  32'd0);
      check("glitch_ferr_n",  32'(ferr_cnt - f0),   32'd0);
      check("glitch_data",    32'(data_out),        32'h55);
      check("glitch_busy",    32'(busy),            32'h0);
      check("glitch_ticks",   32'(busy_ticks - t0), 32'd7);

      // ---------------- framing error 0xC3 ----------------
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(1'b0, 8'hC3, 8, 1'b0, 48);
      wait_clks(3 * BIT_CLKS);
      @(negedge clk);
      check("c3_ferr_n",  32'(ferr_cnt - f0),  32'd1);
      check("c3_valid_n", 32'(valid_cnt - v0), 32'd0);
      check("c3_data",    32'(data_out),       32'hC3);
      check("c3_busy",    32'(busy),           32'h0);

      // ---------------- back-to-back 0xA3, 0x0F ----------------
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(1'b0, 8'hA3, 8, 1'b1, BIT_CLKS);
      send_frame(1'b0, 8'h0F, 8, 1'b1, BIT_CLKS);
      wait_clks(2 * BIT_CLKS);
      @(negedge clk);
      check("b2b_valid_n", 32'(valid_cnt - v0), 32'd2);
      check("b2b_ferr_n",  32'(ferr_cnt - f0),  32'd0);
      check("b2b_first",   32'(vlog[v0 % 16]),       32'hA3);
      check("b2b_second",  32'(vlog[(v0 + 1) % 16]), 32'h0F);

      // ---------------- reset mid-frame 0x7E, then 0x81 ----------------
      v0 = valid_cnt; f0 = ferr_cnt;
      v50 = valid5_cnt; f50 = ferr5_cnt;
      drive(1'b0, 1'b0);            // start
      wait_clks(BIT_CLKS);
      drive(1'b0, 1'b0);            // bit0 of 0x7E
      wait_clks(BIT_CLKS);
      drive(1'b0, 1'b1);            // bit1
      wait_clks(BIT_CLKS);
      drive(1'b0, 1'b1);            // bit2, reset lands mid-bit
      wait_clks(BIT_CLKS / 2);
      rst = 1'b1;
      wait_clks(4);
      @(negedge clk);
      check("mid_rst_data",  32'(data_out),   32'h0);
      check("mid_rst_valid", 32'(data_valid), 32'h0);
      check("mid_rst_ferr",  32'(frame_err),  32'h0);
      check("mid_rst_busy",  32'(busy),       32'h0);
      drive(1'b0, 1'b1);
      wait_clks(10);
      rst = 1'b0;
      wait_clks(BIT_CLKS);
      send_frame(1'b0, 8'h81, 8, 1'b1, BIT_CLKS);
      wait_clks(2 * BIT_CLKS);
      @(negedge clk);
      check("abort_valid_n", 32'(valid_cnt - v0), 32'd1);
      check("abort_ferr_n",  32'(ferr_cnt - f0),  32'd0);
      check("f81_data",      32'(data_out),       32'h81);
      check("f81_busy",      32'(busy),           32'h0);

      // ---------------- 5-bit instance, frame 0x15 ----------------
      v0 = valid_cnt;
      t50 = busy5_ticks;
      send_frame(1'b1, 8'h15, 5, 1'b1, BIT_CLKS);
      wait_clks(2 * BIT_CLKS);
      @(negedge clk);
      check("db5_data",    32'(data_out5),          32'h15);
      check("db5_valid_n", 32'(valid5_cnt - v50),   32'd1);
      check("db5_ferr_n",  32'(ferr5_cnt - f50),    32'd0);
      // Strobe at tick 8 + 16*6 = 104 after detection.
      check("db5_ticks",   32'(busy5_ticks - t50),  32'd103);
      check("db5_busy",    32'(busy5),              32'h0);
      check("db8_quiet",   32'(valid_cnt - v0),     32'd0);

      // ---------------- strobe integrity over the whole run ----------------
      check("strobe_both",      32'(both_cnt),        32'd0);
      check("strobe_width",     32'(long_cnt),        32'd0);
      check("strobe_with_busy", 32'(busy_strobe_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_rx_ctrl
